// File: rtl/traffic_request_conditioner.sv
// Roadside input conditioner: per-channel sync, debounce, sticky request and wait/urgency tracking.
// Define TRAFFIC_PED_REQ_EN to build the pedestrian channel; otherwise ped_req/ped_urgent are tied low.

module traffic_request_channel #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned WAIT_W          = 8,
  parameter int unsigned URGENT_CYCLES   = 200
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  input  logic served,
  output logic req,
  output logic urgent
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX  = '1;
  localparam logic [WAIT_W-1:0] URGENT_TH = WAIT_W'(URGENT_CYCLES);

  logic              sync1;
  logic              sync2;
  logic              deb;
  logic [CNT_W-1:0]  cnt;
  logic [WAIT_W-1:0] wait_cnt;

  logic              deb_nxt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic              req_nxt;
  logic [WAIT_W-1:0] wait_nxt;
  logic              urgent_nxt;
  logic              rise;
  logic              clr;
  logic              hold;

  // Debounce, request latch and wait/urgency next-state.
  always_comb begin
    deb_nxt    = deb;
    cnt_nxt    = '0;
    rise       = 1'b0;
    clr        = 1'b0;
    hold       = 1'b0;
    req_nxt    = req;
    wait_nxt   = '0;
    urgent_nxt = 1'b0;

    if (sync2 != deb) begin
      if (cnt == CNT_LAST) begin
        deb_nxt = sync2;
      end else begin
        cnt_nxt = cnt + CNT_W'(1);
      end
    end

    // A fresh rising level beats a same-cycle serve; falling levels never drop a request.
    rise    = ~deb & deb_nxt;
    clr     = served & req;
    hold    = req & ~clr;
    req_nxt = rise | hold;

    if (hold) begin
      wait_nxt = (wait_cnt == WAIT_MAX) ? wait_cnt : wait_cnt + WAIT_W'(1);
    end

    urgent_nxt = hold && (wait_cnt >= URGENT_TH);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      deb      <= 1'b0;
      cnt      <= '0;
      req      <= 1'b0;
      wait_cnt <= '0;
      urgent   <= 1'b0;
    end else begin
      sync1    <= raw;
      sync2    <= sync1;
      deb      <= deb_nxt;
      cnt      <= cnt_nxt;
      req      <= req_nxt;
      wait_cnt <= wait_nxt;
      urgent   <= urgent_nxt;
    end
  end

endmodule

module traffic_request_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned WAIT_W          = 8,
  parameter int unsigned URGENT_CYCLES   = 200
) (
  input  logic clk,
  input  logic reset_n,
  input  logic ns_sensor_raw,
  input  logic ew_sensor_raw,
  input  logic ped_button_raw,
  input  logic ns_served,
  input  logic ew_served,
  input  logic ped_served,
  output logic ns_req,
  output logic ew_req,
  output logic ped_req,
  output logic ns_urgent,
  output logic ew_urgent,
  output logic ped_urgent
);

  traffic_request_channel #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .WAIT_W          (WAIT_W),
    .URGENT_CYCLES   (URGENT_CYCLES)
  ) u_ns (
    .clk     (clk),
    .reset_n (reset_n),
    .raw     (ns_sensor_raw),
    .served  (ns_served),
    .req     (ns_req),
    .urgent  (ns_urgent)
  );

  traffic_request_channel #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .WAIT_W          (WAIT_W),
    .URGENT_CYCLES   (URGENT_CYCLES)
  ) u_ew (
    .clk     (clk),
    .reset_n (reset_n),
    .raw     (ew_sensor_raw),
    .served  (ew_served),
    .req     (ew_req),
    .urgent  (ew_urgent)
  );

`ifdef TRAFFIC_PED_REQ_EN
  traffic_request_channel #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .WAIT_W          (WAIT_W),
    .URGENT_CYCLES   (URGENT_CYCLES)
  ) u_ped (
    .clk     (clk),
    .reset_n (reset_n),
    .raw     (ped_button_raw),
    .served  (ped_served),
    .req     (ped_req),
    .urgent  (ped_urgent)
  );
`else
  // Pedestrian channel absent: inputs are sunk, outputs held low.
  logic unused_ped;
  assign unused_ped = ped_button_raw ^ ped_served;
  assign ped_req    = 1'b0;
  assign ped_urgent = 1'b0;
`endif

endmodule

// File: tb/tb_traffic_request_conditioner.sv
// Directed bench for traffic_request_conditioner at default parameters (4 / 8 / 200).
module tb_traffic_request_conditioner;

`ifdef TRAFFIC_PED_REQ_EN
  localparam logic PED_EN = 1'b1;
`else
  localparam logic PED_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n;
  logic ns_sensor_raw, ew_sensor_raw, ped_button_raw;
  logic ns_served, ew_served, ped_served;
  logic ns_req, ew_req, ped_req;
  logic ns_urgent, ew_urgent, ped_urgent;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  traffic_request_conditioner dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .ns_sensor_raw  (ns_sensor_raw),
    .ew_sensor_raw  (ew_sensor_raw),
    .ped_button_raw (ped_button_raw),
    .ns_served      (ns_served),
    .ew_served      (ew_served),
    .ped_served     (ped_served),
    .ns_req         (ns_req),
    .ew_req         (ew_req),
    .ped_req        (ped_req),
    .ns_urgent      (ns_urgent),
    .ew_urgent      (ew_urgent),
    .ped_urgent     (ped_urgent)
  );

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check8(tag, {2'b00, ns_req, ew_req, ped_req, ns_urgent, ew_urgent, ped_urgent}, 8'd0);
  endtask

  // Advance n rising edges, then settle 1 time unit past the last edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n        = 1'b1;
    ns_sensor_raw  = 1'b0;
    ew_sensor_raw  = 1'b0;
    ped_button_raw = 1'b0;
    ns_served      = 1'b0;
    ew_served      = 1'b0;
    ped_served     = 1'b0;

    // Reset: 1.5 cycles low, outputs clear throughout.
    #1 reset_n = 1'b0;
    #2 check_all_zero("reset_async");
    tick(2);
    check_all_zero("reset_held");
    reset_n       = 1'b0;
    reset_n       = 1'b1;
    ns_sensor_raw = 1'b1;

    // Latency: ns_req appears after edge 6.
    tick(5);
    check1("lat_edge5_ns_req", ns_req, 1'b0);
    tick(1);
    check1("lat_edge6_ns_req", ns_req, 1'b1);
    check1("lat_ew_req", ew_req, 1'b0);
    check1("lat_ped_req", ped_req, 1'b0);
    tick(3);
    check1("lat_ns_req_stays", ns_req, 1'b1);

    // Glitch filter: 3-cycle pulse on ew must not register.
    ew_sensor_raw = 1'b1;
    tick(3);
    ew_sensor_raw = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      check1("glitch_ew_req", ew_req, 1'b0);
    end
    check1("glitch_ew_deb", dut.u_ew.deb, 1'b0);

    // Level drop does not clear a held request.
    ns_sensor_raw = 1'b0;
    tick(8);
    check1("hold_ns_deb_low", dut.u_ns.deb, 1'b0);
    check1("hold_ns_req", ns_req, 1'b1);

    // Set and clear on the same edge: set wins, wait restarts.
    ns_sensor_raw = 1'b1;
    tick(5);
    check1("sc_ns_deb_before", dut.u_ns.deb, 1'b0);
    ns_served = 1'b1;
    tick(1);
    ns_served = 1'b0;
    check1("sc_ns_deb_rose", dut.u_ns.deb, 1'b1);
    check1("sc_ns_req", ns_req, 1'b1);
    check8("sc_ns_wait", dut.u_ns.wait_cnt, 8'd0);
    tick(1);
    check8("sc_ns_wait_next", dut.u_ns.wait_cnt, 8'd1);

    // Serve handshake, then a serve with no request pending.
    ns_served = 1'b1;
    tick(1);
    ns_served = 1'b0;
    check1("serve_ns_req", ns_req, 1'b0);
    check1("serve_ns_urgent", ns_urgent, 1'b0);
    ns_served = 1'b1;
    tick(1);
    ns_served = 1'b0;
    check1("serve_idle_ns_req", ns_req, 1'b0);
    tick(3);
    check1("serve_idle_ns_req_later", ns_req, 1'b0);

    // Urgency on ew: rises 201 edges after ew_req, saturates at 255.
    ew_sensor_raw = 1'b1;
    tick(5);
    check1("urg_ew_req_edge5", ew_req, 1'b0);
    tick(1);
    check1("urg_ew_req_set", ew_req, 1'b1);
    check1("urg_ew_urgent_set", ew_urgent, 1'b0);
    tick(200);
    check1("urg_ew_urgent_200", ew_urgent, 1'b0);
    check8("urg_ew_wait_200", dut.u_ew.wait_cnt, 8'd200);
    tick(1);
    check1("urg_ew_urgent_201", ew_urgent, 1'b1);
    check1("urg_ew_req_201", ew_req, 1'b1);
    tick(60);
    check8("urg_ew_wait_sat", dut.u_ew.wait_cnt, 8'd255);
    check1("urg_ew_urgent_sat", ew_urgent, 1'b1);
    check1("urg_ns_urgent", ns_urgent, 1'b0);
    ew_served = 1'b1;
    tick(1);
    ew_served = 1'b0;
    check1("urg_ew_req_served", ew_req, 1'b0);
    check1("urg_ew_urgent_served", ew_urgent, 1'b0);
    check8("urg_ew_wait_served", dut.u_ew.wait_cnt, 8'd0);

    // Reset mid-operation with all raw inputs high.
    ns_sensor_raw = 1'b0;
    ew_sensor_raw = 1'b0;
    tick(10);
    ns_sensor_raw  = 1'b1;
    ew_sensor_raw  = 1'b1;
    ped_button_raw = 1'b1;
    tick(6);
    check1("mid_ns_req_pending", ns_req, 1'b1);
    check1("mid_ew_req_pending", ew_req, 1'b1);
    check1("mid_ped_req_pending", ped_req, PED_EN);
    #2 reset_n = 1'b0;
    #1 check_all_zero("mid_reset_async");
    check1("mid_reset_ns_deb", dut.u_ns.deb, 1'b0);
    tick(1);
    check_all_zero("mid_reset_held");
    reset_n = 1'b1;
    tick(5);
    check_all_zero("mid_release_edge5");
    tick(1);
    check1("mid_release_ns_req", ns_req, 1'b1);
    check1("mid_release_ew_req", ew_req, 1'b1);
    check1("mid_release_ped_req", ped_req, PED_EN);
    check1("mid_release_ped_urgent", ped_urgent, 1'b0);

    // Pedestrian serve: clears when built, stays low when not.
    ped_served = 1'b1;
    tick(1);
    ped_served = 1'b0;
    check1("ped_served_req", ped_req, 1'b0);
    check1("ped_served_urgent", ped_urgent, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/traffic_request_conditioner.md
Name: traffic_request_conditioner

Overview:
- Upstream front-end for the stoplight controller. Conditions raw, asynchronous roadside inputs (north-south car sensor, east-west car sensor, pedestrian button) into clean request signals.
- Each input passes through a two-flop synchronizer, then a debounce filter, then a sticky request latch.
- A request stays asserted until the stoplight returns a one-cycle "served" pulse.
- A per-request wait counter flags requests that have waited too long, so the stoplight can shorten its current phase.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive synchronized cycles an input must hold a new level before the debounced level changes. Legal range is 1 to 255.
- WAIT_W, 8: width of each wait counter. Counters saturate at 2^WAIT_W-1.
- URGENT_CYCLES, 200: wait count at or above which the matching urgent output asserts. Must be less than or equal to 2^WAIT_W-1.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- ns_sensor_raw  in  1  north-south car presence, asynchronous.
- ew_sensor_raw  in  1  east-west car presence, asynchronous.
- ped_button_raw  in  1  pedestrian push button, asynchronous.
- ns_served  in  1  one-cycle pulse from the stoplight; clears ns_req.
- ew_served  in  1  one-cycle pulse; clears ew_req.
- ped_served  in  1  one-cycle pulse; clears ped_req.
- ns_req  out  1  pending north-south request, registered.
- ew_req  out  1  pending east-west request, registered.
- ped_req  out  1  pending pedestrian request, registered.
- ns_urgent  out  1  ns_req pending with wait count >= URGENT_CYCLES.
- ew_urgent  out  1  same, for east-west.
- ped_urgent  out  1  same, for pedestrian.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low. Asserting reset_n low immediately clears all synchronizer flops, debounced levels, debounce counters, wait counters and all six outputs to 0.
- Reset mid-operation: pending requests are lost. After release, an input that is still high is treated as a fresh 0-to-1 transition, because the debounced level resets to 0.
- Channels: the three channels are identical and fully independent. Each has sync1, sync2, a debounce counter cnt of width clog2(DEBOUNCE_CYCLES)+1, a debounced level deb, req, wait and urgent.
- Synchronizer: sync1 <= raw; sync2 <= sync1.
- Debounce, when sync2 == deb: cnt <= 0.
- Debounce, when sync2 != deb and cnt < DEBOUNCE_CYCLES-1: cnt <= cnt+1.
- Debounce, when sync2 != deb and cnt == DEBOUNCE_CYCLES-1: deb <= sync2 and cnt <= 0.
- Glitch filtering: any pulse or dropout of the raw input shorter than DEBOUNCE_CYCLES synchronized cycles never changes deb.
- Request set: a deb transition from 0 to 1 sets req on the same edge that deb updates.
- Latency: raw rises, and is first captured at edge 1. req is high after edge DEBOUNCE_CYCLES+2, which is edge 6 at the default.
- Request clear: served=1 with req=1 clears req at the next edge. served with req=0 is ignored.
- Set and clear in the same cycle: set wins, so req stays 1 and wait restarts at 0.
- Level-independent hold: a deb transition from 1 to 0 does not clear req. Once registered, a request is held until served.
- Wait counter: while req=1 and no clear occurs this cycle, wait <= wait+1, saturating at 2^WAIT_W-1. When req is 0 or is being cleared, wait <= 0.
- Urgent: urgent <= (req && wait >= URGENT_CYCLES), registered. urgent deasserts on the same edge as req.
- Timing: there are no combinational paths from inputs to outputs.

Optional Feature:
- Macro: TRAFFIC_PED_REQ_EN.
- When defined: the pedestrian channel is built as described above.
- When undefined: the pedestrian channel logic is not instantiated. ped_req and ped_urgent are constant 0. ped_button_raw and ped_served are ignored. The port list is unchanged.

Test Plan:
- Reset and latency (DEBOUNCE_CYCLES=4): hold reset_n=0 for 1.5 cycles, release, then raise ns_sensor_raw just before edge 1 and hold it. All outputs are 0 during reset; ns_req=1 after edge 6 and stays 1; ew_req and ped_req stay 0.
- Glitch filter: pulse ew_sensor_raw high for 3 cycles, then low. ew_req stays 0; debounced ew level stays 0.
- Serve handshake: with ns_req=1, pulse ns_served for one cycle. ns_req=0 after the next edge; a second ns_served while ns_req=0 causes no change.
- Simultaneous set and clear: time ped_served to land on the cycle in which the pedestrian deb rises while ped_req=1. ped_req stays 1 and its wait restarts at 0.
- Urgency (URGENT_CYCLES=200, WAIT_W=8): leave ew_req unserved. ew_urgent rises 201 edges after ew_req rises, the wait counter saturates at 255, then ew_served drops ew_req and ew_urgent together.
- Reset mid-operation and option check: assert reset_n low with all requests pending while raw inputs stay high. All outputs clear immediately, and requests re-assert DEBOUNCE_CYCLES+2 edges after release. With TRAFFIC_PED_REQ_EN undefined, ped_req stays 0 throughout.
